// File: rtl/apb_init_pkg.sv
`default_nettype none
// ============================================================================
// apb_init_pkg : shared state type, default widths and timeout sizing helper
// Revision     : 1.0 - initial release
// ============================================================================
package apb_init_pkg;

  localparam int C_DEFAULT_ADDR_W = 16;
  localparam int C_DEFAULT_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  // Counter width able to hold TIMEOUT_CYCLES; never narrower than one bit.
  function automatic int timeout_width(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_init_timeout.sv
`default_nettype none
// ============================================================================
// apb_init_timeout : saturating wait-state counter with clear/enable/expire
// Revision         : 1.0 - initial release
// ============================================================================
module apb_init_timeout
  import apb_init_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = timeout_width(TIMEOUT_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam logic [CNT_W-1:0] C_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_SAT = '1;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_clr) begin
      count_d = '0;
    end else if (i_en && (count_q != C_SAT)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Expiry is flagged while the last permitted ACCESS cycle is in progress.
  assign o_expire = (TIMEOUT_CYCLES != 0) && (count_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/apb_cmd_initiator.sv
`default_nettype none
// ============================================================================
// apb_cmd_initiator : valid/ready command stream to single APB transfers
// Revision          : 1.0 - initial release
// ============================================================================
module apb_cmd_initiator
  import apb_init_pkg::*;
#(
  parameter int ADDR_W         = C_DEFAULT_ADDR_W,
  parameter int DATA_W         = C_DEFAULT_DATA_W,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam logic [ADDR_W-1:0] C_WORD_MASK = ~ADDR_W'(3);

  apb_state_e        state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic w_accept;
  logic w_wait;
  logic w_expire;

  assign w_accept = (state_q == ST_IDLE) && cmd_valid;
  assign w_wait   = (state_q == ST_ACCESS) && !pready;

  apb_init_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (pclk),
    .rst_n    (presetn),
    .i_clr    (w_accept),
    .i_en     (w_wait),
    .o_expire (w_expire)
  );

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          pwrite_d  = cmd_write;
          paddr_d   = cmd_addr & C_WORD_MASK;
          pwdata_d  = cmd_write ? cmd_wdata : '0;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        // pready takes priority over a timeout expiring in the same cycle.
        if (pready) begin
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          rsp_err_d   = pslverr;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else if (w_expire) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q     <= ST_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_cmd_initiator.sv
`default_nettype none
// tb_apb_cmd_initiator : vector table, hand-written corner sequences and
// randomized commands checked against a transaction-level model.
module tb_apb_cmd_initiator;

  localparam int AW        = 16;
  localparam int DW        = 32;
  localparam int TO        = 8;
  localparam int ACC_LIMIT = 40;
  localparam int N_VEC     = 10;
  localparam int N_RAND    = 40;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            waits;   // ACCESS cycles with pready low before it rises
    logic [DW-1:0] prdata;
    logic          slverr;
    int            hold;    // RESP cycles with rsp_ready low
    logic [AW-1:0] e_paddr;
    logic [DW-1:0] e_pwdata;
    logic [DW-1:0] e_rdata;
    logic          e_err;
    int            e_acc;
  } vec_t;

  logic          pclk      = 1'b0;
  logic          presetn   = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr  = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] prdata    = '0;
  logic          pready    = 1'b0;
  logic          pslverr   = 1'b0;
  logic          cmd_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;

  int n_cmp  = 0;
  int n_fail = 0;

  vec_t vecs [N_VEC];

  always #5 pclk = ~pclk;

  apb_cmd_initiator #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .pclk      (pclk),
    .presetn   (presetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Transaction-level expectation: word-aligned address, write data only on
  // writes, and a response that is either the responder's or a timeout error.
  function automatic vec_t model(input logic wr, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata, input int waits,
                                 input logic [DW-1:0] rd, input logic se,
                                 input int hold);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.waits = waits;
    v.prdata = rd; v.slverr = se; v.hold = hold;
    v.e_paddr  = addr - (addr % 4);
    v.e_pwdata = wr ? wdata : 32'd0;
    if (waits < TO) begin
      v.e_acc   = waits + 1;
      v.e_err   = se;
      v.e_rdata = wr ? 32'd0 : rd;
    end else begin
      v.e_acc   = TO;
      v.e_err   = 1'b1;
      v.e_rdata = 32'd0;
    end
    return v;
  endfunction

  // Entered mid-cycle with the DUT idle; leaves it mid-cycle idle again.
  task automatic run_cmd(input vec_t v);
    int acc;
    cmd_valid = 1'b1;
    cmd_write = v.wr;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    #1;
    chk("cmd_ready_idle", cmd_ready, 1);
    @(posedge pclk); #1;
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = 16'($urandom);
    cmd_wdata = $urandom;
    @(negedge pclk);
    chk("setup_psel", psel, 1);
    chk("setup_penable", penable, 0);
    chk("setup_paddr", paddr, v.e_paddr);
    chk("setup_pwrite", pwrite, v.wr);
    chk("setup_pwdata", pwdata, v.e_pwdata);
    chk("setup_cmd_ready", cmd_ready, 0);
    @(posedge pclk); #1;
    acc = 0;
    while (psel && penable && acc < ACC_LIMIT) begin
      pready    = (acc == v.waits);
      prdata    = pready ? v.prdata : $urandom;
      pslverr   = pready ? v.slverr : 1'($urandom);
      rsp_ready = 1'($urandom);
      @(negedge pclk);
      chk("access_paddr", paddr, v.e_paddr);
      chk("access_pwrite", pwrite, v.wr);
      chk("access_pwdata", pwdata, v.e_pwdata);
      acc++;
      @(posedge pclk); #1;
    end
    pready    = 1'b0;
    pslverr   = 1'b0;
    rsp_ready = 1'b0;
    chk("access_cycles", acc, v.e_acc);
    for (int h = 0; h < v.hold; h++) begin
      @(negedge pclk);
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_rsp_rdata", rsp_rdata, v.e_rdata);
      chk("hold_rsp_err", rsp_err, v.e_err);
      chk("hold_cmd_ready", cmd_ready, 0);
      chk("hold_psel", psel, 0);
      @(posedge pclk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge pclk);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_rdata", rsp_rdata, v.e_rdata);
    chk("rsp_err", rsp_err, v.e_err);
    chk("resp_psel", psel, 0);
    chk("resp_penable", penable, 0);
    @(posedge pclk); #1;
    rsp_ready = 1'b0;
    @(negedge pclk);
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_cmd_ready", cmd_ready, 1);
    chk("post_psel", psel, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //        wr    addr      wdata          waits prdata         se   hold paddr     pwdata         rdata          err  acc
    vecs[0] = '{1'b1, 16'h0008, 32'h00000003, 0,  32'h0BAD0BAD, 1'b0, 0, 16'h0008, 32'h00000003, 32'h00000000, 1'b0, 1};
    vecs[1] = '{1'b0, 16'h0005, 32'hDEADBEEF, 0,  32'hFFFFFFF0, 1'b0, 0, 16'h0004, 32'h00000000, 32'hFFFFFFF0, 1'b0, 1};
    vecs[2] = '{1'b0, 16'h0010, 32'h00000000, 3,  32'hA5A5A5A5, 1'b0, 1, 16'h0010, 32'h00000000, 32'hA5A5A5A5, 1'b0, 4};
    vecs[3] = '{1'b0, 16'h0020, 32'h00000000, 99, 32'h77777777, 1'b0, 0, 16'h0020, 32'h00000000, 32'h00000000, 1'b1, 8};
    vecs[4] = '{1'b1, 16'h0024, 32'h11223344, 0,  32'h0,        1'b0, 0, 16'h0024, 32'h11223344, 32'h00000000, 1'b0, 1};
    vecs[5] = '{1'b0, 16'h0030, 32'h00000000, 0,  32'h00001234, 1'b1, 0, 16'h0030, 32'h00000000, 32'h00001234, 1'b1, 1};
    vecs[6] = '{1'b0, 16'h0034, 32'h00000000, 7,  32'hCAFEF00D, 1'b0, 0, 16'h0034, 32'h00000000, 32'hCAFEF00D, 1'b0, 8};
    vecs[7] = '{1'b1, 16'h0FFE, 32'h89ABCDEF, 2,  32'h55555555, 1'b1, 2, 16'h0FFC, 32'h89ABCDEF, 32'h00000000, 1'b1, 3};
    vecs[8] = '{1'b1, 16'hFFFF, 32'h0F0F0F0F, 8,  32'h0,        1'b0, 0, 16'hFFFC, 32'h0F0F0F0F, 32'h00000000, 1'b1, 8};
    vecs[9] = '{1'b0, 16'h0040, 32'h00000000, 1,  32'h00000055, 1'b0, 5, 16'h0040, 32'h00000000, 32'h00000055, 1'b0, 2};

    presetn = 1'b0;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    presetn = 1'b1;
    @(negedge pclk);
    chk("rst_cmd_ready", cmd_ready, 1);

    for (int i = 0; i < N_VEC; i++) begin
      run_cmd(vecs[i]);
    end

    // Reset while a read is parked in ACCESS waiting for pready.
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 16'h0050;
    @(posedge pclk); #1;
    cmd_valid = 1'b0;
    @(posedge pclk); #1;
    @(posedge pclk); #1;
    chk("pre_reset_access", {30'd0, psel, penable}, 32'd3);
    presetn = 1'b0;
    @(posedge pclk); #1;
    presetn = 1'b1;
    @(negedge pclk);
    chk("midrst_psel", psel, 0);
    chk("midrst_penable", penable, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_cmd_ready", cmd_ready, 1);
    chk("midrst_paddr", paddr, 0);
    run_cmd(model(1'b0, 16'h0058, 32'h0, 5, 32'h600DF00D, 1'b0, 0));

    for (int i = 0; i < N_RAND; i++) begin
      run_cmd(model(1'($urandom), 16'($urandom), $urandom,
                    int'($urandom_range(0, 11)), $urandom,
                    1'($urandom_range(0, 3) == 0), int'($urandom_range(0, 3))));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
